// File: rtl/axi4_lite_regbank.sv
// AXI4-Lite control/status register bank: R/W registers, read-only status slots,
// SLVERR on bad writes, and per-register write-commit pulses toward user logic.
module axi4_lite_regbank #(
  parameter int C_AXI_DATA_WIDTH = 32,
  parameter int C_AXI_ADDR_WIDTH = 8,
  parameter int C_REGISTERS_NUMBER = 16,
  parameter logic [C_REGISTERS_NUMBER-1:0] C_RO_MASK = '0,
  parameter logic [C_AXI_DATA_WIDTH-1:0] C_RESET_VALUE = '0,
  localparam int C_AXI_STROBE_WIDTH = C_AXI_DATA_WIDTH / 8
) (
  input  logic                                         S_AXI_ACLK,
  input  logic                                         S_AXI_ARESET,
  input  logic                                         S_AXI_AWVALID,
  output logic                                         S_AXI_AWREADY,
  input  logic [C_AXI_ADDR_WIDTH-1:0]                  S_AXI_AWADDR,
  input  logic [2:0]                                   S_AXI_AWPROT,
  input  logic                                         S_AXI_WVALID,
  output logic                                         S_AXI_WREADY,
  input  logic [C_AXI_DATA_WIDTH-1:0]                  S_AXI_WDATA,
  input  logic [C_AXI_STROBE_WIDTH-1:0]                S_AXI_WSTRB,
  output logic                                         S_AXI_BVALID,
  input  logic                                         S_AXI_BREADY,
  output logic [1:0]                                   S_AXI_BRESP,
  input  logic                                         S_AXI_ARVALID,
  output logic                                         S_AXI_ARREADY,
  input  logic [C_AXI_ADDR_WIDTH-1:0]                  S_AXI_ARADDR,
  input  logic [2:0]                                   S_AXI_ARPROT,
  output logic                                         S_AXI_RVALID,
  input  logic                                         S_AXI_RREADY,
  output logic [C_AXI_DATA_WIDTH-1:0]                  S_AXI_RDATA,
  output logic [1:0]                                   S_AXI_RRESP,
  output logic [C_REGISTERS_NUMBER*C_AXI_DATA_WIDTH-1:0] USR_REGS,
  input  logic [C_REGISTERS_NUMBER*C_AXI_DATA_WIDTH-1:0] USR_STATUS,
  output logic [C_REGISTERS_NUMBER-1:0]                USR_WR_STROBE
);

  localparam int C_ADDR_LSB = $clog2(C_AXI_STROBE_WIDTH);
  localparam int IDX_W = C_AXI_ADDR_WIDTH - C_ADDR_LSB;
  localparam logic [1:0] RESP_OKAY = 2'b00;
  localparam logic [1:0] RESP_SLVERR = 2'b10;

  logic                          aw_full_q, aw_full_d;
  logic                          w_full_q, w_full_d;
  logic [IDX_W-1:0]              aw_idx_q;
  logic [C_AXI_DATA_WIDTH-1:0]   w_data_q;
  logic [C_AXI_STROBE_WIDTH-1:0] w_strb_q;
  logic                          awready_q, wready_q, arready_q;
  logic                          bvalid_q, rvalid_q, rvalid_d;
  logic [1:0]                    bresp_q, rresp_q;
  logic [C_AXI_DATA_WIDTH-1:0]   rdata_q;
  logic [C_REGISTERS_NUMBER-1:0] strobe_q;
  logic [C_AXI_DATA_WIDTH-1:0]   regs_q [C_REGISTERS_NUMBER];

  logic                          aw_hs, w_hs, ar_hs, commit;
  logic [C_REGISTERS_NUMBER-1:0] wr_sel;
  logic                          wr_ok;
  logic [IDX_W-1:0]              ar_idx;
  logic [C_AXI_DATA_WIDTH-1:0]   rd_data_c;
  logic                          rd_err_c;
  logic                          unused_ok;

  assign unused_ok = ^{S_AXI_AWPROT, S_AXI_ARPROT, S_AXI_AWADDR[C_ADDR_LSB-1:0],
                       S_AXI_ARADDR[C_ADDR_LSB-1:0], USR_STATUS};

  assign aw_hs  = S_AXI_AWVALID && awready_q;
  assign w_hs   = S_AXI_WVALID && wready_q;
  assign ar_hs  = S_AXI_ARVALID && arready_q;
  assign commit = aw_full_q && w_full_q && !bvalid_q;
  assign ar_idx = S_AXI_ARADDR[C_AXI_ADDR_WIDTH-1:C_ADDR_LSB];

  assign aw_full_d = commit ? 1'b0 : (aw_hs ? 1'b1 : aw_full_q);
  assign w_full_d  = commit ? 1'b0 : (w_hs ? 1'b1 : w_full_q);
  assign rvalid_d  = ar_hs ? 1'b1 : ((rvalid_q && S_AXI_RREADY) ? 1'b0 : rvalid_q);

  // An empty select covers both out-of-range and read-only targets.
  always_comb begin
    wr_sel = '0;
    for (int i = 0; i < C_REGISTERS_NUMBER; i++) begin
      if (aw_idx_q == IDX_W'(i) && !C_RO_MASK[i]) wr_sel[i] = 1'b1;
    end
    wr_ok = |wr_sel;
  end

  always_comb begin
    rd_data_c = '0;
    rd_err_c  = 1'b1;
    for (int i = 0; i < C_REGISTERS_NUMBER; i++) begin
      if (ar_idx == IDX_W'(i)) begin
        rd_err_c  = 1'b0;
        rd_data_c = C_RO_MASK[i] ? USR_STATUS[i*C_AXI_DATA_WIDTH +: C_AXI_DATA_WIDTH] : regs_q[i];
      end
    end
  end

  always_comb begin
    USR_REGS = '0;
    for (int i = 0; i < C_REGISTERS_NUMBER; i++) begin
      USR_REGS[i*C_AXI_DATA_WIDTH +: C_AXI_DATA_WIDTH] = C_RO_MASK[i] ? '0 : regs_q[i];
    end
  end

  always_ff @(posedge S_AXI_ACLK or posedge S_AXI_ARESET) begin
    if (S_AXI_ARESET) begin
      aw_full_q <= 1'b0;
      w_full_q  <= 1'b0;
      aw_idx_q  <= '0;
      w_data_q  <= '0;
      w_strb_q  <= '0;
      awready_q <= 1'b0;
      wready_q  <= 1'b0;
      arready_q <= 1'b0;
      bvalid_q  <= 1'b0;
      bresp_q   <= RESP_OKAY;
      rvalid_q  <= 1'b0;
      rresp_q   <= RESP_OKAY;
      rdata_q   <= '0;
      strobe_q  <= '0;
    end else begin
      aw_full_q <= aw_full_d;
      w_full_q  <= w_full_d;
      // Readies track the next slot state so they rise one edge after reset.
      awready_q <= !aw_full_d;
      wready_q  <= !w_full_d;
      arready_q <= !rvalid_d;
      rvalid_q  <= rvalid_d;
      if (aw_hs) aw_idx_q <= S_AXI_AWADDR[C_AXI_ADDR_WIDTH-1:C_ADDR_LSB];
      if (w_hs) begin
        w_data_q <= S_AXI_WDATA;
        w_strb_q <= S_AXI_WSTRB;
      end
      strobe_q <= commit ? wr_sel : '0;
      if (commit) begin
        bvalid_q <= 1'b1;
        bresp_q  <= wr_ok ? RESP_OKAY : RESP_SLVERR;
      end else if (bvalid_q && S_AXI_BREADY) begin
        bvalid_q <= 1'b0;
      end
      if (ar_hs) begin
        rdata_q <= rd_data_c;
        rresp_q <= rd_err_c ? RESP_SLVERR : RESP_OKAY;
      end
    end
  end

  always_ff @(posedge S_AXI_ACLK or posedge S_AXI_ARESET) begin
    if (S_AXI_ARESET) begin
      for (int i = 0; i < C_REGISTERS_NUMBER; i++) regs_q[i] <= C_RESET_VALUE;
    end else begin
      for (int i = 0; i < C_REGISTERS_NUMBER; i++) begin
        for (int b = 0; b < C_AXI_STROBE_WIDTH; b++) begin
          if (commit && wr_sel[i] && w_strb_q[b]) regs_q[i][b*8 +: 8] <= w_data_q[b*8 +: 8];
        end
      end
    end
  end

  assign S_AXI_AWREADY = awready_q;
  assign S_AXI_WREADY  = wready_q;
  assign S_AXI_ARREADY = arready_q;
  assign S_AXI_BVALID  = bvalid_q;
  assign S_AXI_BRESP   = bresp_q;
  assign S_AXI_RVALID  = rvalid_q;
  assign S_AXI_RRESP   = rresp_q;
  assign S_AXI_RDATA   = rdata_q;
  assign USR_WR_STROBE = strobe_q;

endmodule

// File: doc/axi4_lite_regbank.md
# axi4_lite_regbank

Parametrised AXI4-Lite slave register bank, the next generation of the single-width register-file slave. Generalises data width and register count. Adds:
- independent, order-free AW/W acceptance;
- read-only status registers sourced from user logic;
- SLVERR for out-of-range and read-only writes;
- per-register write-commit strobes toward user logic.

It sits between the AXI4-Lite interconnect and the user datapath as the control/status register block.

## Interface
Parameters:
- C_AXI_DATA_WIDTH, 32, data width; 32 or 64 only. C_AXI_STROBE_WIDTH = C_AXI_DATA_WIDTH/8. C_ADDR_LSB = log2(C_AXI_STROBE_WIDTH).
- C_AXI_ADDR_WIDTH, 8, byte address width.
- C_REGISTERS_NUMBER, 16, register count; 2..2^(C_AXI_ADDR_WIDTH-C_ADDR_LSB).
- C_RO_MASK, 0 (C_REGISTERS_NUMBER bits), bit i=1 makes register i read-only, sourced from USR_STATUS.
- C_RESET_VALUE, 0, reset value of every read/write register.

Ports:
- **Clock and reset**
  - S_AXI_ACLK in 1: clock.
  - S_AXI_ARESET in 1: asynchronous, active-high reset.
- **Write address:** S_AXI_AWVALID in 1; S_AXI_AWREADY out 1; S_AXI_AWADDR in C_AXI_ADDR_WIDTH; S_AXI_AWPROT in 3 (ignored).
- **Write data:** S_AXI_WVALID in 1; S_AXI_WREADY out 1; S_AXI_WDATA in C_AXI_DATA_WIDTH; S_AXI_WSTRB in C_AXI_STROBE_WIDTH.
- **Write response:** S_AXI_BVALID out 1; S_AXI_BREADY in 1; S_AXI_BRESP out 2.
- **Read address:** S_AXI_ARVALID in 1; S_AXI_ARREADY out 1; S_AXI_ARADDR in C_AXI_ADDR_WIDTH; S_AXI_ARPROT in 3 (ignored).
- **Read data:** S_AXI_RVALID out 1; S_AXI_RREADY in 1; S_AXI_RDATA out C_AXI_DATA_WIDTH; S_AXI_RRESP out 2.
- **User side**
  - USR_REGS out C_REGISTERS_NUMBER*C_AXI_DATA_WIDTH: flattened register contents; register i is at bits [i*W +: W]. Read-only slots drive 0.
  - USR_STATUS in C_REGISTERS_NUMBER*C_AXI_DATA_WIDTH: status values for read-only slots; other slots are ignored.
  - USR_WR_STROBE out C_REGISTERS_NUMBER: one-cycle pulse on bit i when register i is written with OKAY.

## Operation
- **Index:** addr[C_AXI_ADDR_WIDTH-1:C_ADDR_LSB]. Low address bits are ignored.
- **Write path:** two holding slots, aw_full and w_full.
  - AWREADY = !aw_full; WREADY = !w_full. Both are registered.
  - An AW handshake latches the index and sets aw_full. A W handshake latches WDATA/WSTRB and sets w_full.
  - AW and W may arrive in either order or in the same cycle.
- **Commit:** occurs on the edge where aw_full && w_full && !BVALID.
  - If index >= C_REGISTERS_NUMBER or C_RO_MASK[index]: no register change, BRESP=2'b10 (SLVERR), no strobe.
  - Otherwise: byte lanes with WSTRB[b]=1 are written, BRESP=2'b00, USR_WR_STROBE[index] pulses.
  - WSTRB=0 with a valid index still gives OKAY and a strobe pulse, with data unchanged.
  - The commit sets BVALID and clears both slots.
- **Write response:** BVALID holds, with BRESP stable, until BREADY is sampled high; then it clears.
  - New AW/W may be accepted while BVALID is pending. Their commit waits until BVALID clears.
- **Read path:** ARREADY = !RVALID && !S_AXI_ARESET.
  - On an AR handshake, RDATA/RRESP are captured from the current state and RVALID is set.
  - Read/write register: value before any commit on the same edge. Read-only: USR_STATUS slice, OKAY. Out of range: RDATA=0, SLVERR.
- **RDATA/RRESP hold:** held stable while RVALID=1 && !RREADY. On an R handshake, RVALID clears and RDATA/RRESP keep their value.
- **Independence:** read and write paths are fully independent. A same-edge read and write to one register returns the old value.
- **Reset (async, any time):**
  - AWREADY/WREADY/ARREADY=0 and BVALID/RVALID=0.
  - BRESP/RRESP=2'b00, RDATA=0, USR_WR_STROBE=0.
  - Both slots are cleared, registers load C_RESET_VALUE, and in-flight transactions are dropped with no response.
  - AWREADY/WREADY/ARREADY rise on the first S_AXI_ACLK edge after reset release.

## Timing
- **Write, AW+W same edge E0:** commit and BVALID=1 at E1, USR_WR_STROBE high for the cycle E1..E2, USR_REGS updated at E1. With BREADY held high, BVALID clears at E2.
- **Write, split arrival:** commit occurs one edge after the later of the two handshakes.
- **Write throughput:** one write per 2 cycles with BREADY held high.
- **Read:** AR handshake at E0 gives RVALID=1 at E0. With RREADY held high, RVALID clears at E1 and ARREADY is high in the following cycle, giving 2-cycle read throughput.
- **Ready/valid rules:** no combinational path from any VALID/READY input to any output. Outputs never drop VALID before the handshake.

## Test plan
- **Reset values:** hold reset for 3 cycles -> all outputs at reset values and USR_REGS=0. One edge after release -> AWREADY=WREADY=ARREADY=1.
- **Full write then read:** AW+W same cycle, addr 0x08, WDATA=0xDEADBEEF, WSTRB=4'hF -> BVALID next edge with BRESP=0 and USR_WR_STROBE[2] one pulse. Read of 0x08 -> 0xDEADBEEF, OKAY.
- **Strobe and split arrival:** W first (WDATA=0x11223344, WSTRB=4'b0101), AW to 0x08 three cycles later -> register becomes 0xDE22BE44. BREADY held low for 4 cycles -> BVALID/BRESP stable throughout.
- **Errors:** write to read-only register 3 with USR_STATUS slice 0xCAFE0001 -> SLVERR, no strobe, read returns 0xCAFE0001. Write/read of index 20 with C_REGISTERS_NUMBER=16 -> SLVERR, RDATA=0.
- **Collision and backpressure:** same-edge read and write to register 1 -> read returns the old value. RREADY held low for 5 cycles -> RDATA stable and ARREADY=0.
- **Mid-transaction reset:** assert reset while aw_full=1 -> no BVALID ever appears for that transaction and the register is unchanged. Repeat the write test with C_AXI_DATA_WIDTH=64.
